// File: rtl/e_mdu_pkg.sv
// Shared MDU operation encodings and the MDU sequencer states.
// Decode and hazard logic import the same values.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding HI/LO; mult/div commit MULT_CYCLES/DIV_CYCLES edges after Start.
// No backpressure: Busy tells the hazard unit to stall MDU ops in D; mthi/mtlo take one edge.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    mdu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero, div_ovf;
    logic        [31:0] dvs_s, dvs_u;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic               start_arith;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where A/1 is exactly the wrapped answer.
    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign dvs_s    = (div_zero || div_ovf) ? 32'd1 : B;
    assign dvs_u    = div_zero ? 32'd1 : B;
    assign quo_s    = $signed(A) / $signed(dvs_s);
    assign rem_s    = $signed(A) % $signed(dvs_s);
    assign quo_u    = A / dvs_u;
    assign rem_u    = A % dvs_u;

    assign start_arith = Start && ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU) ||
                                   (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_arith) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'(DIV_CYCLES);
                    case (MDUOp)
                        MDU_MULT: begin
                            tmp_hi_d = prod_s[63:32];
                            tmp_lo_d = prod_s[31:0];
                            cnt_d    = 4'(MULT_CYCLES);
                        end
                        MDU_MULTU: begin
                            tmp_hi_d = prod_u[63:32];
                            tmp_lo_d = prod_u[31:0];
                            cnt_d    = 4'(MULT_CYCLES);
                        end
                        MDU_DIV: begin
                            tmp_hi_d = div_zero ? hi_q : rem_s;
                            tmp_lo_d = div_zero ? lo_q : quo_s;
                        end
                        default: begin
                            tmp_hi_d = div_zero ? hi_q : rem_u;
                            tmp_lo_d = div_zero ? lo_q : quo_u;
                        end
                    endcase
                end else if (MDUOp == MDU_MTHI) begin
                    hi_d = A;
                end else if (MDUOp == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            default: begin
                if (cnt_q == 4'd1) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDUOut = 32'd0;
        if (MDUOp == MDU_MFHI)      MDUOut = hi_q;
        else if (MDUOp == MDU_MFLO) MDUOut = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed checks of e_mdu: arithmetic results, Busy length, /0, mid-run reset, mt*/mf* paths.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO, MDUOut;

    int checks = 0;
    int fails  = 0;
    int start_in_run = 0;
    int mt_in_run    = 0;
    int n;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    // Protocol watchers: Start or mthi/mtlo while an operation is in flight.
    always @(posedge clk) begin
        if (!reset && Busy === 1'b1 && Start === 1'b1) start_in_run++;
        if (!reset && Busy === 1'b1 && (MDUOp === 4'd7 || MDUOp === 4'd8)) mt_in_run++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a Start and count Busy cycles (bounded); returns at the first negedge with Busy low.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        MDUOp = op; A = a;
        @(negedge clk);
        MDUOp = 4'd0;
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; MDUOp = 4'd0; Start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", MDUOut, 32'd0);

        run(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        chk("mult_cyc", 32'(n), 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        MDUOp = 4'd5;
        #1 chk("mfhi_first_idle", MDUOut, 32'hFFFF_FFFF);

        run(4'd2, 32'hFFFF_FFFE, 32'd3, n);
        chk("multu_cyc", 32'(n), 32'd5);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        run(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_cyc", 32'(n), 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        run(4'd3, 32'd7, 32'hFFFF_FFFE, n);
        chk("div_negb_lo", LO, 32'hFFFF_FFFD);
        chk("div_negb_hi", HI, 32'd1);

        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_lo", LO, 32'h8000_0000);
        chk("div_ovf_hi", HI, 32'd0);

        run(4'd4, 32'd7, 32'd2, n);
        chk("divu_cyc", 32'(n), 32'd10);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        mt(4'd7, 32'h11);
        chk("mthi", HI, 32'h11);
        mt(4'd8, 32'h22);
        chk("mtlo", LO, 32'h22);
        run(4'd3, 32'd5, 32'd0, n);
        chk("div0_cyc", 32'(n), 32'd10);
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);

        // Reset asserted during the third Busy cycle of a mult.
        @(negedge clk);
        MDUOp = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_hi_late", HI, 32'd0);
        chk("abort_lo_late", LO, 32'd0);

        // mthi issued mid-run is dropped.
        @(negedge clk);
        MDUOp = 4'd2; A = 32'd2; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd7; A = 32'hDEAD_BEEF;
        @(negedge clk);
        MDUOp = 4'd0;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("mthi_run_hi", HI, 32'd0);
        chk("mthi_run_lo", LO, 32'd6);

        mt(4'd7, 32'hAAAA_0000);
        mt(4'd8, 32'h0000_BBBB);
        MDUOp = 4'd5;
        #1 chk("mux_mfhi", MDUOut, 32'hAAAA_0000);
        MDUOp = 4'd6;
        #1 chk("mux_mflo", MDUOut, 32'h0000_BBBB);
        MDUOp = 4'd0;
        #1 chk("mux_none", MDUOut, 32'd0);
        MDUOp = 4'd12;
        #1 chk("mux_op12", MDUOut, 32'd0);
        MDUOp = 4'd0;

        @(negedge clk);
        chk("start_in_run", 32'(start_in_run), 32'd0);
        chk("mt_in_run", 32'(mt_in_run), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# E_MDU

Execute-stage multiply/divide unit: consumes the decoded MDU operation and the forwarded rs/rt values, runs signed/unsigned multiply and divide as multi-cycle operations, and holds the architectural HI/LO registers. It sits beside the ALU in the E stage, fed by the decode control unit through the D/E pipeline register. Its `Busy` output goes to the hazard unit, which stalls any MDU instruction in D. `MDUOut` joins the E-stage result mux for mfhi/mflo.

## Interface

Reset is synchronous and active-high; one clock.

**Parameters** (name, default, meaning)
- `MULT_CYCLES`, 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, 10: Busy cycles for div/divu.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `A`, in, 32: forwarded rs value.
- `B`, in, 32: forwarded rt value.
- `MDUOp`, in, 4: operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - 9–15 behave as none.
- `Start`, in, 1: one-cycle pulse; MDUOp is mult/multu/div/divu and the E stage is not stalled.
- `Busy`, out, 1: an operation is in flight.
- `HI`, out, 32: architectural HI register.
- `LO`, out, 32: architectural LO register.
- `MDUOut`, out, 32: combinational. HI when MDUOp=mfhi, LO when MDUOp=mflo, else 0.

## Operation

**Reset**
- HI, LO, Busy, the cycle counter and the temp result registers all become 0.
- Reset mid-operation aborts the operation; no HI/LO update follows.

**State**
- Two states: IDLE (Busy=0) and RUN (Busy=1).
- Internal down-counter `cnt`, 4 bits, wide enough for DIV_CYCLES.

**IDLE, Start=1 with MDUOp in {1..4}**
- Compute the result combinationally from A and B; latch it into `tmp_hi`/`tmp_lo`.
- Load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN.

**IDLE, Start=1 with any other MDUOp**
- Ignored.

**Arithmetic**
- mult: 64-bit signed product of A and B; `tmp_hi` = [63:32], `tmp_lo` = [31:0].
- multu: same, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
- div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): the temp registers take the current HI/LO, so HI/LO end unchanged; Busy still lasts DIV_CYCLES.

**RUN**
- `cnt` decrements every cycle.
- On the edge where `cnt`==1: HI←`tmp_hi`, LO←`tmp_lo`, Busy←0, `cnt`←0; go to IDLE.
- Start during RUN is ignored. The hazard unit guarantees this never happens; the bench asserts it.

**mthi / mtlo**
- In IDLE: HI←A (mthi) or LO←A (mtlo) at the next edge; Start is not required.
- During RUN: ignored; flagged by a bench assertion.

## Timing

- Start sampled at edge E0. Busy is high from just after E0 for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new values at edge E0+N.
- Busy falls at the same edge E0+N. Therefore an mfhi issued in the first cycle with Busy=0 reads the new value.
- Back-to-back operations: a Start sampled at the same edge Busy falls is invalid. The next accepted Start is at E0+N+1 at the earliest, since the hazard unit sees Busy/Start.
- mthi/mtlo latency: 1 edge.
- mfhi/mflo: zero latency, combinational from the registers.
- MULT_CYCLES and DIV_CYCLES must be ≥1 and ≤15.

## Structure

- MDUOp encodings (MDU_NONE … MDU_MTLO) go in the shared macro header, next to the ALUCtrl/ExtSel codes, so the decode CU and the hazard unit use the same values.
- No sub-module: the 64-bit product/divide operators plus the counter FSM fit in one module.
- The decode CU gains the MDUOp output. The hazard unit gains the stall term `D_isMDU && (E_Start || E_Busy)`.

## Test plan

1. **mult:** A=0xFFFFFFFE, B=3, Start → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. **multu:** same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
3. **div / divu:** A=-7, B=2 → after 10 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). A=0x80000000, B=-1 → LO=0x80000000, HI=0. divu A=7, B=2 → LO=3, HI=1.
4. **Divide by zero:** after mthi 0x11, mtlo 0x22, run div with B=0 → Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
5. **Reset mid-run:** reset in cycle 3 of a mult → Busy=0, HI=LO=0 next cycle, no later update. Also: a mthi during Busy is ignored.
6. **mfhi/mflo mux:** with HI=0xAAAA0000, LO=0x0000BBBB, MDUOp=mfhi → MDUOut=0xAAAA0000; mflo → 0x0000BBBB; none → 0.
